// File: rtl/gpu_pkg.sv
// Shared definitions for the sprite/instruction dispatch path.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package gpu_pkg;

    // Instruction opcodes carried in dataA[3:0]
    localparam logic [3:0] OP_POS  = 4'd0;
    localparam logic [3:0] OP_MEM  = 4'd1;
    localparam logic [3:0] OP_OFS  = 4'd2;
    localparam logic [3:0] OP_WAIT = 4'd3;

    // Dispatch FSM states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DECODE     = 3'd1,
        REG_WR     = 3'd2,
        MEM_WR     = 3'd3,
        WAIT_FRAME = 3'd4
    } state_t;

    // One FIFO entry: payload in the upper word, opcode/address word below
    typedef struct packed {
        logic [31:0] data_b;
        logic [31:0] data_a;
    } instr_t;

    // Position and offset writes share the register-write path
    function automatic logic is_reg_op(input logic [3:0] op);
        return (op == OP_POS) || (op == OP_OFS);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: DEPTH x WIDTH, combinational head read, sticky overflow flag.
// Latency: a push is visible at the head (empty=0) one cycle after it is written.
// Backpressure: none upstream; a push while full is dropped and latched in overflow,
//   unless a pop happens in the same cycle, which frees the slot.
// Ports: clk, reset (async active-low), push/push_data, pop/pop_data, full, empty, overflow.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is ignored; a pop frees a slot for a same-cycle push.
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != FULL_CNT) || do_pop);
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_dispatch_ctrl.sv
// Instruction dispatcher: queues {dataA,dataB} pushes and executes them one at a time
//   as sprite register writes, sprite memory writes or end-of-frame waits.
// Latency: push at cycle N into an idle, empty block gives reg_wr/mem_wr at N+3.
// Backpressure: mem_wr holds until mem_ready; WAIT_FRAME holds until screen_done;
//   pushes into a full FIFO are dropped and flagged by the sticky overflow output.
// Ports: clk, reset; wr_en/dataA/dataB push side; screen_done, mem_ready;
//   reg_wr/reg_sel/reg_addr/reg_data; mem_wr/mem_addr/mem_data; status flags.
module instr_dispatch_ctrl
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic        screen_done,
    input  logic        mem_ready,
    output logic        reg_wr,
    output logic        reg_sel,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic        mem_wr,
    output logic [16:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        busy,
    output logic        illegal_op,
    output logic        overflow
);

    state_t     state;
    state_t     state_nxt;
    instr_t     push_word;
    instr_t     head;
    instr_t     instr;
    logic [3:0] opcode;
    logic       pop;
    logic       unused_hi_bits;

    assign push_word      = '{data_b: dataB, data_a: dataA};
    assign opcode         = instr.data_a[3:0];
    assign unused_hi_bits = ^instr.data_a[31:21];

    // Only IDLE consumes entries, so a push into an empty FIFO is never popped
    // in the same cycle.
    assign pop = (state == IDLE) && !fifo_empty;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (!fifo_empty) state_nxt = DECODE;
            DECODE: begin
                if (is_reg_op(opcode))     state_nxt = REG_WR;
                else if (opcode == OP_MEM) state_nxt = MEM_WR;
                else if (opcode == OP_WAIT) state_nxt = WAIT_FRAME;
                else                       state_nxt = IDLE;
            end
            REG_WR:     state_nxt = IDLE;
            MEM_WR:     if (mem_ready) state_nxt = IDLE;
            WAIT_FRAME: if (screen_done) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        reg_wr     = (state == REG_WR);
        mem_wr     = (state == MEM_WR);
        illegal_op = (state == DECODE) && (opcode > OP_WAIT);
        busy       = (state != IDLE) || !fifo_empty;
    end

    // Instruction register and registered write-port fields. The fields are
    // loaded on leaving DECODE, so they hold steady for the whole MEM_WR stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr    <= '0;
            reg_sel  <= 1'b0;
            reg_addr <= '0;
            reg_data <= '0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            if (pop) instr <= head;
            if (state == DECODE) begin
                reg_sel  <= opcode[1];
                reg_addr <= instr.data_a[8:4];
                reg_data <= instr.data_b;
                mem_addr <= instr.data_a[20:4];
                mem_data <= instr.data_b;
            end
        end
    end

endmodule
